// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the two-port data-memory arbiter.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DBG = 1'b1;

  localparam int unsigned MEM_DEPTH_DEFAULT = 256;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester ports (CPU and loader/debug) plus the data-memory pins, bundled.
interface dmem_arbiter_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 16
);
  logic              req0;
  logic              we0;
  logic [ADDR_W-1:0] addr0;
  logic [DATA_W-1:0] wdata0;
  logic              req1;
  logic              we1;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata1;

  logic              gnt0;
  logic              gnt1;
  logic              rvalid0;
  logic              rvalid1;
  logic [DATA_W-1:0] rdata0;
  logic [DATA_W-1:0] rdata1;
  logic              err0;
  logic              err1;

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_read;
  logic              mem_write;
  logic [DATA_W-1:0] mem_rdata;

  // Arbiter side.
  modport slave (
    input  req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, mem_rdata,
    output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, err0, err1,
           mem_addr, mem_wdata, mem_read, mem_write
  );

  // Requesters and memory side.
  modport master (
    output req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, mem_rdata,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, err0, err1,
           mem_addr, mem_wdata, mem_read, mem_write
  );
endinterface

// File: rtl/dmem_arbiter_rr_arb2.sv
// Combinational two-way picker: round-robin on contention, or port 0 first when fixed_prio.
module rr_arb2
  import dmem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_winner,
  input  logic       fixed_prio,
  output logic       win_valid,
  output logic       win_idx
);

  always_comb begin
    win_valid = |req;
    win_idx   = PORT_CPU;
    if (req == 2'b10) begin
      win_idx = PORT_DBG;
    end else if (req == 2'b11) begin
      win_idx = fixed_prio ? PORT_CPU : ~last_winner;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter and access sequencer for the 16-bit data memory.
// Every memory-side pin is a flop so the level-sensitive write enable sees stable addr/data.
//
// state  | meaning
// IDLE   | no access in flight; arbitrate on every edge
// ACCESS | memory pins driven for the granted port; capture read data at the edge
// RESP   | rvalid/err/rdata presented; a pending request is arbitrated at the edge
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned MEM_DEPTH  = MEM_DEPTH_DEFAULT,
  parameter bit          FIXED_PRIO = 1'b0
) (
  input  logic           clk,
  input  logic           rst_n,
  dmem_arbiter_if.slave  bus
);

  state_t state;
  logic   last_winner;
  logic   lat_idx;
  logic   lat_we;
  logic   lat_in_range;

  logic              win_valid;
  logic              win_idx;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              sel_in_range;
  logic [DATA_W-1:0] rd_value;

  rr_arb2 u_rr_arb2 (
    .req         ({bus.req1, bus.req0}),
    .last_winner (last_winner),
    .fixed_prio  (FIXED_PRIO),
    .win_valid   (win_valid),
    .win_idx     (win_idx)
  );

  assign sel_we    = (win_idx == PORT_DBG) ? bus.we1    : bus.we0;
  assign sel_addr  = (win_idx == PORT_DBG) ? bus.addr1  : bus.addr0;
  assign sel_wdata = (win_idx == PORT_DBG) ? bus.wdata1 : bus.wdata0;

  // Full-width compare: high address bits must never alias into the implemented range.
  assign sel_in_range = (32'(sel_addr) < MEM_DEPTH);

  assign rd_value = (lat_in_range && !lat_we) ? bus.mem_rdata : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      last_winner   <= PORT_DBG;
      lat_idx       <= 1'b0;
      lat_we        <= 1'b0;
      lat_in_range  <= 1'b0;
      bus.gnt0      <= 1'b0;
      bus.gnt1      <= 1'b0;
      bus.rvalid0   <= 1'b0;
      bus.rvalid1   <= 1'b0;
      bus.rdata0    <= '0;
      bus.rdata1    <= '0;
      bus.err0      <= 1'b0;
      bus.err1      <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.mem_read  <= 1'b0;
      bus.mem_write <= 1'b0;
    end else begin
      bus.gnt0    <= 1'b0;
      bus.gnt1    <= 1'b0;
      bus.rvalid0 <= 1'b0;
      bus.rvalid1 <= 1'b0;
      bus.err0    <= 1'b0;
      bus.err1    <= 1'b0;
      bus.rdata0  <= '0;
      bus.rdata1  <= '0;

      case (state)
        IDLE, RESP: begin
          bus.mem_addr  <= '0;
          bus.mem_wdata <= '0;
          bus.mem_read  <= 1'b0;
          bus.mem_write <= 1'b0;
          if (win_valid) begin
            lat_idx      <= win_idx;
            lat_we       <= sel_we;
            lat_in_range <= sel_in_range;
            last_winner  <= win_idx;
            bus.gnt0     <= (win_idx == PORT_CPU);
            bus.gnt1     <= (win_idx == PORT_DBG);
            if (sel_in_range) begin
              bus.mem_addr  <= sel_addr;
              bus.mem_wdata <= sel_wdata;
              bus.mem_read  <= !sel_we;
              bus.mem_write <= sel_we;
            end
            state <= ACCESS;
          end else begin
            state <= IDLE;
          end
        end

        ACCESS: begin
          bus.mem_addr  <= '0;
          bus.mem_wdata <= '0;
          bus.mem_read  <= 1'b0;
          bus.mem_write <= 1'b0;
          if (lat_idx == PORT_DBG) begin
            bus.rvalid1 <= 1'b1;
            bus.err1    <= !lat_in_range;
            bus.rdata1  <= rd_value;
          end else begin
            bus.rvalid0 <= 1'b1;
            bus.err0    <= !lat_in_range;
            bus.rdata0  <= rd_value;
          end
          state <= RESP;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed vector bench for dmem_arbiter: round-robin instance (a) and fixed-priority instance (b).
module tb_dmem_arbiter;

  typedef struct packed {
    logic        req0;
    logic        we0;
    logic [15:0] addr0;
    logic [15:0] wdata0;
    logic        req1;
    logic        we1;
    logic [15:0] addr1;
    logic [15:0] wdata1;
  } in_t;

  typedef struct packed {
    logic        gnt0;
    logic        gnt1;
    logic        rvalid0;
    logic        rvalid1;
    logic        err0;
    logic        err1;
    logic        mem_read;
    logic        mem_write;
    logic [15:0] rdata0;
    logic [15:0] rdata1;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
  } out_t;

  typedef struct {
    in_t  i;
    out_t o;
  } vec_t;

  logic clk;
  logic rst_n;
  in_t  drv;

  int n_checks;
  int n_fail;
  int ovl;

  logic [15:0] mem_a [0:255];
  logic [15:0] mem_b [0:255];

  dmem_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus_a ();
  dmem_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus_b ();

  dmem_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_DEPTH(256), .FIXED_PRIO(1'b0)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a)
  );

  dmem_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_DEPTH(256), .FIXED_PRIO(1'b1)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bus_a.req0 = drv.req0;   assign bus_b.req0 = drv.req0;
  assign bus_a.we0 = drv.we0;     assign bus_b.we0 = drv.we0;
  assign bus_a.addr0 = drv.addr0; assign bus_b.addr0 = drv.addr0;
  assign bus_a.wdata0 = drv.wdata0; assign bus_b.wdata0 = drv.wdata0;
  assign bus_a.req1 = drv.req1;   assign bus_b.req1 = drv.req1;
  assign bus_a.we1 = drv.we1;     assign bus_b.we1 = drv.we1;
  assign bus_a.addr1 = drv.addr1; assign bus_b.addr1 = drv.addr1;
  assign bus_a.wdata1 = drv.wdata1; assign bus_b.wdata1 = drv.wdata1;

  // Memory models: level-sensitive write captured at the edge ending ACCESS, combinational read.
  assign bus_a.mem_rdata = (bus_a.mem_addr < 16'd256) ? mem_a[bus_a.mem_addr[7:0]] : 16'd0;
  assign bus_b.mem_rdata = (bus_b.mem_addr < 16'd256) ? mem_b[bus_b.mem_addr[7:0]] : 16'd0;

  always @(posedge clk) begin
    if (bus_a.mem_write && bus_a.mem_addr < 16'd256) mem_a[bus_a.mem_addr[7:0]] <= bus_a.mem_wdata;
    if (bus_b.mem_write && bus_b.mem_addr < 16'd256) mem_b[bus_b.mem_addr[7:0]] <= bus_b.mem_wdata;
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus_a.gnt0 && bus_a.gnt1) ovl++;
      if (bus_a.rvalid0 && bus_a.rvalid1) ovl++;
      if (bus_b.gnt0 && bus_b.gnt1) ovl++;
      if (bus_b.rvalid0 && bus_b.rvalid1) ovl++;
    end
  end

  function automatic in_t mk_in(input int r0, input int w0, input int a0, input int d0,
                                input int r1, input int w1, input int a1, input int d1);
    in_t x;
    x.req0 = (r0 != 0); x.we0 = (w0 != 0); x.addr0 = 16'(a0); x.wdata0 = 16'(d0);
    x.req1 = (r1 != 0); x.we1 = (w1 != 0); x.addr1 = 16'(a1); x.wdata1 = 16'(d1);
    return x;
  endfunction

  function automatic out_t mk_out(input int g0, input int g1, input int v0, input int v1,
                                  input int e0, input int e1, input int rd, input int wr,
                                  input int rd0, input int rd1, input int ma, input int mw);
    out_t x;
    x.gnt0 = (g0 != 0); x.gnt1 = (g1 != 0); x.rvalid0 = (v0 != 0); x.rvalid1 = (v1 != 0);
    x.err0 = (e0 != 0); x.err1 = (e1 != 0); x.mem_read = (rd != 0); x.mem_write = (wr != 0);
    x.rdata0 = 16'(rd0); x.rdata1 = 16'(rd1); x.mem_addr = 16'(ma); x.mem_wdata = 16'(mw);
    return x;
  endfunction

  // rdata/err are only meaningful alongside rvalid; masked unless raw view requested.
  function automatic out_t get_out(input bit sel_b, input bit mask);
    out_t x;
    if (sel_b) begin
      x.gnt0 = bus_b.gnt0; x.gnt1 = bus_b.gnt1; x.rvalid0 = bus_b.rvalid0; x.rvalid1 = bus_b.rvalid1;
      x.err0 = bus_b.err0; x.err1 = bus_b.err1; x.mem_read = bus_b.mem_read; x.mem_write = bus_b.mem_write;
      x.rdata0 = bus_b.rdata0; x.rdata1 = bus_b.rdata1; x.mem_addr = bus_b.mem_addr; x.mem_wdata = bus_b.mem_wdata;
    end else begin
      x.gnt0 = bus_a.gnt0; x.gnt1 = bus_a.gnt1; x.rvalid0 = bus_a.rvalid0; x.rvalid1 = bus_a.rvalid1;
      x.err0 = bus_a.err0; x.err1 = bus_a.err1; x.mem_read = bus_a.mem_read; x.mem_write = bus_a.mem_write;
      x.rdata0 = bus_a.rdata0; x.rdata1 = bus_a.rdata1; x.mem_addr = bus_a.mem_addr; x.mem_wdata = bus_a.mem_wdata;
    end
    if (mask && !x.rvalid0) begin x.rdata0 = '0; x.err0 = 1'b0; end
    if (mask && !x.rvalid1) begin x.rdata1 = '0; x.err1 = 1'b0; end
    return x;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  vec_t vecs [22];
  int   n0;
  int   early1;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    ovl      = 0;
    for (int k = 0; k < 256; k++) begin
      mem_a[k] = 16'd0;
      mem_b[k] = 16'd0;
    end
    mem_a[17]  = 16'd22;     mem_b[17]  = 16'd22;
    mem_a[255] = 16'h5A5A;   mem_b[255] = 16'h5A5A;

    // Port 0 write 44 @15, port 1 read @15.
    vecs[0]  = '{mk_in(1,1,15,44, 0,0,0,0),   mk_out(1,0,0,0,0,0,0,1, 0,0,15,44)};
    vecs[1]  = '{mk_in(0,0,0,0, 0,0,0,0),     mk_out(0,0,1,0,0,0,0,0, 0,0,0,0)};
    vecs[2]  = '{mk_in(0,0,0,0, 1,0,15,0),    mk_out(0,1,0,0,0,0,1,0, 0,0,15,0)};
    vecs[3]  = '{mk_in(0,0,0,0, 0,0,0,0),     mk_out(0,0,0,1,0,0,0,0, 0,44,0,0)};
    vecs[4]  = '{mk_in(0,0,0,0, 0,0,0,0),     mk_out(0,0,0,0,0,0,0,0, 0,0,0,0)};
    // Port 1 write 7 @0x100 (out of range), then read @0.
    vecs[5]  = '{mk_in(0,0,0,0, 1,1,256,7),   mk_out(0,1,0,0,0,0,0,0, 0,0,0,0)};
    vecs[6]  = '{mk_in(0,0,0,0, 0,0,0,0),     mk_out(0,0,0,1,0,1,0,0, 0,0,0,0)};
    vecs[7]  = '{mk_in(0,0,0,0, 1,0,0,0),     mk_out(0,1,0,0,0,0,1,0, 0,0,0,0)};
    vecs[8]  = '{mk_in(0,0,0,0, 0,0,0,0),     mk_out(0,0,0,1,0,0,0,0, 0,0,0,0)};
    vecs[9]  = '{mk_in(0,0,0,0, 0,0,0,0),     mk_out(0,0,0,0,0,0,0,0, 0,0,0,0)};
    // Last implemented word.
    vecs[10] = '{mk_in(1,0,255,0, 0,0,0,0),   mk_out(1,0,0,0,0,0,1,0, 0,0,255,0)};
    vecs[11] = '{mk_in(0,0,0,0, 0,0,0,0),     mk_out(0,0,1,0,0,0,0,0, 16'h5A5A,0,0,0)};
    vecs[12] = '{mk_in(0,0,0,0, 0,0,0,0),     mk_out(0,0,0,0,0,0,0,0, 0,0,0,0)};
    // Continuous contention; port 0 won last, so port 1 goes first.
    for (int k = 0; k < 2; k++) begin
      vecs[13+4*k] = '{mk_in(1,0,17,0, 1,0,15,0), mk_out(0,1,0,0,0,0,1,0, 0,0,15,0)};
      vecs[14+4*k] = '{mk_in(1,0,17,0, 1,0,15,0), mk_out(0,0,0,1,0,0,0,0, 0,44,0,0)};
      vecs[15+4*k] = '{mk_in(1,0,17,0, 1,0,15,0), mk_out(1,0,0,0,0,0,1,0, 0,0,17,0)};
      vecs[16+4*k] = '{mk_in(1,0,17,0, 1,0,15,0), mk_out(0,0,1,0,0,0,0,0, 22,0,0,0)};
    end
    vecs[21] = '{mk_in(0,0,0,0, 0,0,0,0),     mk_out(0,0,0,0,0,0,0,0, 0,0,0,0)};

    drv   = '0;
    rst_n = 1'b0;
    #2;
    check("reset_outputs_a", 128'(get_out(1'b0, 1'b0)), 128'(0));
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    for (int k = 0; k < 22; k++) begin
      @(negedge clk) drv = vecs[k].i;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d", k), 128'(get_out(1'b0, 1'b1)), 128'(vecs[k].o));
    end

    // Fixed priority: port 0 held keeps winning; port 1 gets the next arbitration once req0 drops.
    n0     = 0;
    early1 = 0;
    @(negedge clk) drv = mk_in(1,0,17,0, 1,0,15,0);
    for (int c = 0; c < 20 && n0 < 4; c++) begin
      @(posedge clk);
      #1;
      if (bus_b.gnt1) early1++;
      if (bus_b.gnt0) n0++;
      if (bus_b.rvalid0) check("prio_rdata0", 128'(bus_b.rdata0), 128'(22));
    end
    check("prio_gnt0_count", 128'(n0), 128'(4));
    check("prio_no_gnt1", 128'(early1), 128'(0));
    @(negedge clk) drv = mk_in(0,0,0,0, 1,0,15,0);
    @(posedge clk);
    #1;
    check("prio_last_rvalid0", 128'({bus_b.rvalid0, bus_b.rdata0}), 128'({1'b1, 16'd22}));
    @(posedge clk);
    #1;
    check("prio_gnt1_after_drop", 128'({bus_b.gnt0, bus_b.gnt1}), 128'(2'b01));
    @(negedge clk) drv = '0;
    @(posedge clk);
    #1;
    check("prio_rdata1", 128'({bus_b.rvalid1, bus_b.rdata1}), 128'({1'b1, 16'd44}));
    repeat (3) @(negedge clk);

    // Reset during the ACCESS cycle of a write to 20.
    drv = mk_in(1,1,20,16'h1234, 0,0,0,0);
    @(posedge clk);
    #1;
    check("rst_write_granted", 128'(get_out(1'b0, 1'b1)), 128'(mk_out(1,0,0,0,0,0,0,1, 0,0,20,16'h1234)));
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_zero_a", 128'(get_out(1'b0, 1'b0)), 128'(0));
    check("rst_async_zero_b", 128'(get_out(1'b1, 1'b0)), 128'(0));
    @(negedge clk) drv = '0;
    @(posedge clk);
    #1;
    check("rst_held_zero_a", 128'(get_out(1'b0, 1'b0)), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    check("rst_write_dropped", 128'(mem_a[20]), 128'(0));
    drv = mk_in(1,0,17,0, 1,0,15,0);
    @(posedge clk);
    #1;
    check("rst_first_contention_a", 128'(get_out(1'b0, 1'b1)), 128'(mk_out(1,0,0,0,0,0,1,0, 0,0,17,0)));
    check("rst_first_contention_b", 128'({bus_b.gnt0, bus_b.gnt1}), 128'(2'b10));
    @(negedge clk) drv = '0;
    repeat (3) @(negedge clk);

    check("single_gnt_rvalid", 128'(ovl), 128'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and access sequencer for the single-cycle datapath's 16-bit data memory. It shares the memory between the CPU load/store port (port 0) and the loader/debug port (port 1). All memory-side controls are registered, so the level-sensitive memory write enable only ever sees stable address and data. It sits between the requesters and the data memory instance, which it drives directly through its MemRead/MemWrite/addr/write_data/read_data pins.

## Interface
- ADDR_W, 16, address width
- DATA_W, 16, data width
- MEM_DEPTH, 256, number of implemented words; addresses >= MEM_DEPTH are out of range
- FIXED_PRIO, 0, 0 = round-robin; 1 = port 0 always wins contention
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- req0 / req1  in  1  access request, level
- we0 / we1  in  1  1 = write, 0 = read; qualified by req
- addr0 / addr1  in  ADDR_W  word address
- wdata0 / wdata1  in  DATA_W  write data
- gnt0 / gnt1  out  1  one-cycle grant pulse
- rvalid0 / rvalid1  out  1  one-cycle completion pulse, for reads and writes
- rdata0 / rdata1  out  DATA_W  read data, valid with rvalid; 0 for writes and errors
- err0 / err1  out  1  out-of-range flag, valid with rvalid
- mem_addr  out  ADDR_W  to memory addr
- mem_wdata  out  DATA_W  to memory write_data
- mem_read  out  1  to memory MemRead
- mem_write  out  1  to memory MemWrite
- mem_rdata  in  DATA_W  from memory read_data (combinational read)

## Operation
- FSM states: IDLE, ACCESS, RESP.
  - IDLE: arbitrate on each edge.
  - ACCESS: lasts one cycle, then goes to RESP.
  - RESP: lasts one cycle. If any req is sampled, arbitrate and go to ACCESS; otherwise go to IDLE.
- Arbitration:
  - Single request: that port wins.
  - Contention with FIXED_PRIO=0: the port not granted last wins. last_winner resets to 1, so port 0 wins the first contention.
  - Contention with FIXED_PRIO=1: port 0 wins. last_winner is still updated.
- On a grant edge:
  - Latch the winner's index, we, addr and wdata.
  - Drive mem_addr, mem_wdata and mem_read (=!we) or mem_write (=we) from the latched values.
  - Raise gnt of the winner.
- Out-of-range (latched addr >= MEM_DEPTH):
  - mem_read and mem_write stay 0.
  - mem_addr and mem_wdata stay 0.
  - err pulses with rvalid; rdata=0.
- ACCESS edge:
  - Capture mem_rdata into the winner's rdata for in-range reads.
  - Pulse rvalid (and err if applicable) for the winner.
  - Clear all mem_* outputs to 0.
- Requester rules:
  - Hold req, we, addr and wdata stable until gnt is seen.
  - Deassert req before the RESP-state edge, unless issuing a new request.
  - A req high at a RESP or IDLE edge is a new request.
- The losing port's req stays pending; it is granted no later than the next arbitration.
- Reset values of all outputs, and of the latched registers, are 0.
- last_winner resets to 1.

## Timing
- Request latency: req high at edge E1 gives gnt high in cycle E1–E2 and rvalid high in cycle E2–E3.
- Throughput: one access per 2 cycles when requests are back-to-back.
- mem_* are registered. They are non-zero only during ACCESS, and constant for the whole ACCESS cycle.
- No combinational path from any req/addr/wdata to any mem_* output or to gnt.
- At most one gnt and one rvalid is high in any cycle.
- Both ports continuously requesting with FIXED_PRIO=0: grants strictly alternate.
- Reset mid-operation (asserted during ACCESS or RESP):
  - All outputs go to 0 immediately, asynchronously; mem_write drops without waiting for clk.
  - The in-flight access is dropped, with no rvalid.
  - State goes to IDLE.
- Address width rule: the MEM_DEPTH compare uses the full ADDR_W bits, with no truncation. Address 0x0100 with MEM_DEPTH=256 is out of range.

## Structure
- Package dmem_arb_pkg holds:
  - the state enum (IDLE, ACCESS, RESP)
  - port index constants PORT_CPU=0 and PORT_DBG=1
  - the default MEM_DEPTH
- Sub-module rr_arb2 is a combinational 2-way round-robin picker.
  - Inputs: req[1:0], last_winner, fixed_prio.
  - Outputs: win_valid, win_idx.
- The FSM, latches and response registers live in dmem_arbiter.

## Test plan
- Port 0 writes 44 to addr 15, then port 1 reads addr 15 -> rdata1=44, rvalid1 two cycles after req, err1=0. mem_write is high for exactly one cycle with mem_addr=15, mem_wdata=44.
- Both ports read continuously, port 0 addr 17 holding 22 and port 1 addr 15 holding 44, FIXED_PRIO=0 -> grants alternate 0,1,0,1; rdata0=22 and rdata1=44 each time; never two gnts in the same cycle.
- Same stimulus with FIXED_PRIO=1 -> only port 0 is granted while req0 is held; port 1 is granted in the first arbitration after req0 drops.
- Port 1 writes addr 256 with data 7 -> err1=1, rdata1=0, mem_write never high; a later read of addr 0 returns 0.
- rst_n pulled low during the ACCESS cycle of a write to addr 20 -> mem_write falls immediately, no rvalid is produced, all outputs are 0; after release, the first contention is granted to port 0.
